// File: rtl/mul32u_seq_pkg.sv
// Shared IP header: FSM state encodings for the sequential multiplier and
// the comparator result codes used by the rest of the shared IP set.
package mul32u_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } mul_state_e;

  typedef enum logic [1:0] {
    CmpLt = 2'b00,
    CmpEq = 2'b01,
    CmpGt = 2'b10
  } cmp_res_e;

  localparam int unsigned DefaultWidth = 32;

endpackage

// File: rtl/mul32u_seq_add64.sv
// Add64: purely combinational unsigned adder with carry-out, built the same
// way as Sub64 (operands zero-extended by one bit, top bit is the carry).
module mul32u_seq_add64 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] full;

  // One extra bit so the carry-out is never lost.
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
  end

  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];

endmodule

// File: rtl/mul32u_seq.sv
// Sequential radix-2 shift-and-add unsigned multiplier. One partial product
// per cycle, WIDTH cycles per operation, result held in prod until the next
// completion.
module mul32u_seq
  import mul32u_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  mul_state_e         state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_q;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic               last_step;
  logic               unused_acc_lsb;

  // Select this step's multiplier bit and gate the multiplicand with it.
  always_comb begin
    addend    = mplier_q[cnt_q[CntW-2:0]] ? mcand_q : '0;
    last_step = (cnt_q == CntW'(WIDTH - 1));
  end

  mul32u_seq_add64 #(
    .WIDTH(WIDTH)
  ) u_add64 (
    .a    (acc_q[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .sum  (sum),
    .cout (carry)
  );

  // Add into the upper half, then shift right by one with the carry entering at the top.
  always_comb begin
    acc_d = {carry, sum, acc_q[WIDTH-1:1]};
  end

  // The LSB is shifted out each step by design.
  assign unused_acc_lsb = acc_q[0];

  // Control FSM plus datapath registers; outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= mcand;
            mplier_q <= mplier;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CntW'(1);
          if (last_step) begin
            prod_q  <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign prod = prod_q;

endmodule

// File: tb/tb_mul32u_seq.sv
// Directed testbench for mul32u_seq (WIDTH = 32) with hand-computed products.
module tb_mul32u_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [63:0] prod;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] prev_prod;

  mul32u_seq #(
    .WIDTH(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .busy   (busy),
    .done   (done),
    .prod   (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; starts one operation and follows it to completion.
  // repulse_at > 0 re-asserts start with other operands in that CALC cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int repulse_at);
    int   busy_cnt;
    logic stable_ok;
    logic got_done;
    busy_cnt  = 0;
    stable_ok = 1'b1;
    got_done  = 1'b0;
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(negedge clk);
    start  = 1'b0;
    mcand  = 32'h5A5A_5A5A;
    mplier = 32'hA5A5_A5A5;
    for (int k = 1; k <= 200; k++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (prod !== prev_prod) stable_ok = 1'b0;
      if (k == repulse_at) begin
        start  = 1'b1;
        mcand  = 32'h0000_DEAD;
        mplier = 32'h0000_BEEF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " done_seen"}, 64'(got_done), 64'd1);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, " prod_stable"}, 64'(stable_ok), 64'd1);
    check({tag, " prod"}, prod, exp);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, " done_pulse_1cyc"}, 64'(done), 64'd0);
    check({tag, " prod_held"}, prod, exp);
    prev_prod = exp;
  endtask

  initial begin
    logic [31:0] ops_a [3];
    logic [31:0] ops_b [3];
    logic [63:0] exps  [3];
    int cyc;
    int last_done;
    int idx;

    ops_a = '{32'd2, 32'd4, 32'd6};
    ops_b = '{32'd3, 32'd5, 32'd7};
    exps  = '{64'd6, 64'd20, 64'd42};

    rst    = 1'b0;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    prev_prod = '0;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset prod", prod, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // First op issued on the very first edge after release.
    run_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("zero", 32'h1234_5678, 32'd0, 64'd0, 0);
    run_op("repulse", 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340, 7);

    // Reset in the 10th CALC cycle.
    run_op("pre_rst", 32'd11, 32'd13, 64'd143, 0);
    start  = 1'b1;
    mcand  = 32'h0000_00AB;
    mplier = 32'h0000_00CD;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_op busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst busy", 64'(busy), 64'd0);
    check("async_rst done", 64'(done), 64'd0);
    check("async_rst prod", prod, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    prev_prod = '0;
    run_op("7x9", 32'd7, 32'd9, 64'd63, 0);

    // Start held high: three back-to-back operations.
    start     = 1'b1;
    mcand     = ops_a[0];
    mplier    = ops_b[0];
    cyc       = 0;
    last_done = 0;
    idx       = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        check($sformatf("b2b prod %0d", idx), prod, exps[idx]);
        if (idx > 0) check($sformatf("b2b period %0d", idx), 64'(cyc - last_done), 64'd34);
        last_done = cyc;
        idx++;
        if (idx == 3) begin
          start = 1'b0;
          break;
        end
        mcand  = ops_a[idx];
        mplier = ops_b[idx];
      end
    end
    start = 1'b0;
    check("b2b count", 64'(idx), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul32u_seq.md
MUL32U_SEQ -- requirements
Module: mul32u_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal values are even integers from 4 to 32.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled on the rising edge of clk.
REQ-005 SHALL have port mcand, input, WIDTH bits: unsigned multiplicand, sampled when start is accepted.
REQ-006 SHALL have port mplier, input, WIDTH bits: unsigned multiplier, sampled when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse when prod is updated.
REQ-009 SHALL have port prod, output, 2*WIDTH bits: unsigned product of the last completed operation.

Function
REQ-010 SHALL use a state machine with three states: IDLE, CALC and DONE.
REQ-011 SHALL accept start only in IDLE; at accepting edge E0 it latches mcand and mplier, clears the accumulator and the iteration counter, and enters CALC.
REQ-012 SHALL in CALC perform one radix-2 shift-and-add step per cycle: if the current multiplier bit is 1, add the multiplicand to the upper half of the accumulator; then shift the accumulator right by 1, carry bit included.
REQ-013 SHALL run exactly WIDTH CALC cycles (edges E1..E_WIDTH); at edge E_WIDTH it loads prod with the full 2*WIDTH-bit accumulator and enters DONE.
REQ-014 SHALL hold done high for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-015 SHALL drive busy high in CALC and low in IDLE and DONE.
REQ-016 SHALL ignore start while in CALC or DONE, with no latching and no queuing.
REQ-017 SHALL keep prod stable from one completion until the next completion; prod SHALL NOT show intermediate values.
REQ-018 SHALL use the carry-out of the adder in each step; no overflow exists because the product fits in 2*WIDTH bits.
REQ-019 SHALL support back-to-back operation: start held high accepts a new operation in the first IDLE cycle after done, giving a period of WIDTH+2 cycles.
REQ-020 SHALL size the iteration counter at clog2(WIDTH)+1 bits, and the counter SHALL NOT wrap during an operation.

Reset
REQ-021 SHALL, while rst is low, force state=IDLE, busy=0, done=0, prod=0, and clear the accumulator, the operand registers and the counter, without waiting for clk.
REQ-022 SHALL abort any operation in progress when reset is asserted mid-operation, discard its partial result and leave prod at 0.
REQ-023 SHALL accept start on the first rising edge of clk after rst deasserts.

Structure
REQ-024 SHALL take the IDLE/CALC/DONE state encodings from the shared IP header, alongside the existing comparator result codes.
REQ-025 SHALL instantiate one sub-module, Add64, from the shared IPs: a (WIDTH+1)-bit unsigned adder that reuses the Sub64 structure and provides carry-out.
REQ-026 SHALL keep all sequential logic in mul32u_seq, and the adder SHALL be purely combinational.

Verification
REQ-027 SHALL check: mcand=3, mplier=5, start pulsed -> busy high for 32 cycles, then done pulse, prod=0x000000000000000F.
REQ-028 SHALL check: mcand=0xFFFFFFFF, mplier=0xFFFFFFFF -> prod=0xFFFFFFFE00000001 at done.
REQ-029 SHALL check: mcand=0x12345678, mplier=0 -> prod=0 at done; before done, prod keeps the previous result.
REQ-030 SHALL check: start re-pulsed with new operands at CALC cycle 7 -> the pulse is ignored, and the result equals the first operands' product.
REQ-031 SHALL check: rst pulled low at CALC cycle 10 -> busy=0, done=0 and prod=0 immediately; then 7*9 after release -> prod=63.
REQ-032 SHALL check: start held high for 3 operations (2*3, 4*5, 6*7) -> done pulses every 34 cycles with prods 6, 20, 42.
